// File: rtl/uart_rx_pkg.sv
// Shared state encoding and timing constants for the UART receive frame sequencer.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } rx_state_e;

  // Majority-of-3 sampling settles two edges past the bit midpoint.
  localparam int CHK_OFFSET = 2;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  function automatic logic prescale_is_legal(input int unsigned ps);
    return (ps == PRESCALE_X8) || (ps == PRESCALE_X16) || (ps == PRESCALE_X32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample (edge) and bit-position counters; edge wraps at last, bit advances on wrap.
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  bit_inc,
  input  logic [PRESCALE_W-1:0] last,
  output logic                  wrap,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [PRESCALE_W-1:0] edge_cnt_nxt,
  output logic [3:0]            bit_cnt
);
  import uart_rx_pkg::*;

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;

  assign wrap         = (edge_cnt_q == last);
  assign edge_cnt     = edge_cnt_q;
  assign edge_cnt_nxt = edge_cnt_d;
  assign bit_cnt      = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en) begin
      if (wrap) begin
        edge_cnt_d = '0;
        if (bit_inc) bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, per-bit checker/deserializer strobes,
// and data_valid qualification of each completed frame.
module uart_rx_fsm #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  str_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  str_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid
);
  import uart_rx_pkg::*;

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_r_q, prescale_r_d;
  logic                  par_en_r_q, par_en_r_d;
  logic                  par_err_sticky_q, par_err_sticky_d;
  logic                  dat_samp_en_q, dat_samp_en_d;
  logic                  str_chk_en_q, str_chk_en_d;
  logic                  deser_en_q, deser_en_d;
  logic                  par_chk_en_q, par_chk_en_d;
  logic                  stp_chk_en_q, stp_chk_en_d;
  logic                  data_valid_q, data_valid_d;

  logic                  wrap;
  logic [PRESCALE_W-1:0] edge_cnt_nxt;
  logic [PRESCALE_W-1:0] last;
  logic [PRESCALE_W-1:0] chk;

  // A zero prescale still yields a one-cycle bit so the frame always terminates.
  assign last = (prescale_r_q == '0) ? '0 : prescale_r_q - PRESCALE_W'(1);
  assign chk  = (prescale_r_q >> 1) + PRESCALE_W'(CHK_OFFSET);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         ((state_q == ST_IDLE) || (state_d == ST_IDLE)),
    .en          (state_q != ST_IDLE),
    .bit_inc     (state_q != ST_PARITY),
    .last        (last),
    .wrap        (wrap),
    .edge_cnt    (edge_cnt),
    .edge_cnt_nxt(edge_cnt_nxt),
    .bit_cnt     (bit_cnt)
  );

  always_comb begin
    state_d          = state_q;
    prescale_r_d     = prescale_r_q;
    par_en_r_d       = par_en_r_q;
    par_err_sticky_d = par_err_sticky_q;
    data_valid_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          state_d          = ST_START;
          prescale_r_d     = prescale;
          par_en_r_d       = par_en;
          par_err_sticky_d = 1'b0;
        end
      end
      ST_START: begin
        if (wrap) state_d = str_glitch ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (wrap && (bit_cnt == 4'(DATA_W))) state_d = par_en_r_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (wrap) begin
          par_err_sticky_d = par_err;
          state_d          = ST_STOP;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          state_d      = ST_IDLE;
          data_valid_d = !(par_err_sticky_q | stp_err);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from next-cycle state/count so they line up with edge_cnt.
    dat_samp_en_d = (state_d != ST_IDLE);
    str_chk_en_d  = (state_d == ST_START)  && (edge_cnt_nxt == chk);
    deser_en_d    = (state_d == ST_DATA)   && (edge_cnt_nxt == chk);
    par_chk_en_d  = (state_d == ST_PARITY) && (edge_cnt_nxt == chk);
    stp_chk_en_d  = (state_d == ST_STOP)   && (edge_cnt_nxt == chk);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      prescale_r_q     <= '0;
      par_en_r_q       <= 1'b0;
      par_err_sticky_q <= 1'b0;
      dat_samp_en_q    <= 1'b0;
      str_chk_en_q     <= 1'b0;
      deser_en_q       <= 1'b0;
      par_chk_en_q     <= 1'b0;
      stp_chk_en_q     <= 1'b0;
      data_valid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      prescale_r_q     <= prescale_r_d;
      par_en_r_q       <= par_en_r_d;
      par_err_sticky_q <= par_err_sticky_d;
      dat_samp_en_q    <= dat_samp_en_d;
      str_chk_en_q     <= str_chk_en_d;
      deser_en_q       <= deser_en_d;
      par_chk_en_q     <= par_chk_en_d;
      stp_chk_en_q     <= stp_chk_en_d;
      data_valid_q     <= data_valid_d;
    end
  end

  assign dat_samp_en = dat_samp_en_q;
  assign str_chk_en  = str_chk_en_q;
  assign deser_en    = deser_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stp_chk_en  = stp_chk_en_q;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: expected strobe/data_valid events are queued per frame
// and matched against the DUT outputs, including cycle, edge_cnt and bit_cnt.
module tb_uart_rx_fsm;
  localparam int PW = 6;
  localparam int DW = 8;

  localparam int K_STR = 0;
  localparam int K_DES = 1;
  localparam int K_PAR = 2;
  localparam int K_STP = 3;
  localparam int K_DV  = 4;

  typedef struct {
    int kind;
    int cyc;
    int ec;
    int bc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic [PW-1:0] prescale;
  logic          str_glitch;
  logic          par_err;
  logic          stp_err;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          str_chk_en;
  logic          deser_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          data_valid;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  ev_t sb[$];

  uart_rx_fsm #(.PRESCALE_W(PW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .prescale   (prescale),
    .str_glitch (str_glitch),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .dat_samp_en(dat_samp_en),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .str_chk_en (str_chk_en),
    .deser_en   (deser_en),
    .par_chk_en (par_chk_en),
    .stp_chk_en (stp_chk_en),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int ec, input int bc);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.ec   = ec;
    e.bc   = bc;
    sb.push_back(e);
  endtask

  // Every strobe or data_valid the DUT raises must be the next queued expectation.
  always @(negedge clk) begin
    logic [4:0] hits;
    hits = {data_valid, stp_chk_en, par_chk_en, deser_en, str_chk_en};
    for (int k = 0; k < 5; k++) begin
      if (hits[k]) begin
        if (sb.size() == 0) begin
          chk("spurious_event_kind", k, -1);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("ev_kind", k, e.kind);
          chk("ev_cyc", cyc, e.cyc);
          chk("ev_edge_cnt", int'(edge_cnt), e.ec);
          chk("ev_bit_cnt", int'(bit_cnt), e.bc);
        end
      end
    end
  end

  task automatic idle(input int c);
    rx_in = 1'b1;
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dat_samp_en"}, int'(dat_samp_en), 0);
    chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
    chk({tag, "_bit_cnt"}, int'(bit_cnt), 0);
    chk({tag, "_strobes"}, int'({str_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
    chk({tag, "_data_valid"}, int'(data_valid), 0);
  endtask

  // Called #1 after a posedge; the FSM detects the start bit on the following edge (n).
  // rst_k >= 0 pulses reset at frame offset rst_k; ps_k >= 0 changes prescale mid-frame.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] data,
                            input bit perr, input bit serr,
                            input int rst_k, input int ps_k, input int ps_new);
    int         n;
    int         bits;
    int         total;
    int         chk_e;
    int         j;
    int         kind;
    logic [10:0] line;
    n     = cyc + 1;
    bits  = 10 + int'(pe);
    total = bits * p;
    chk_e = p / 2 + 2;
    line  = '1;
    line[0]   = 1'b0;
    line[8:1] = data;
    if (pe) line[9] = ^data;
    line[bits-1] = !serr;
    for (int b = 0; b < bits; b++) begin
      j = b * p + chk_e;
      if (b == 0)                kind = K_STR;
      else if (b <= DW)          kind = K_DES;
      else if (pe && b == DW + 1) kind = K_PAR;
      else                       kind = K_STP;
      if (rst_k < 0 || j < rst_k) push_ev(kind, n + j, chk_e, (b > DW + 1) ? DW + 1 : b);
    end
    if (!perr && !serr && rst_k < 0) push_ev(K_DV, n + total, 0, 0);
    prescale = PW'(p);
    par_en   = pe;
    par_err  = perr;
    stp_err  = serr;
    for (int k = 0; k < total; k++) begin
      rx_in = line[k / p];
      if (k == ps_k) prescale = PW'(ps_new);
      if (k == rst_k) rst = 1'b1;
      @(posedge clk);
      #1;
      if (k == rst_k) begin
        rst   = 1'b0;
        rx_in = 1'b1;
        chk_all_zero("mid_frame_reset");
        return;
      end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    rx_in      = 1'b1;
    par_en     = 1'b0;
    prescale   = PW'(8);
    str_glitch = 1'b0;
    par_err    = 1'b0;
    stp_err    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(3);
    chk("idle_dat_samp_en", int'(dat_samp_en), 0);

    // Plain 8N1 frame at x8.
    send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, -1, -1, 0);
    idle(3);
    chk("sb_after_a5", sb.size(), 0);

    // 8E1 frame with correct parity.
    send_frame(8, 1'b1, 8'h3C, 1'b0, 1'b0, -1, -1, 0);
    idle(3);
    chk("sb_after_3c_parity", sb.size(), 0);

    // Start glitch: line low two cycles, checker flags it, FSM abandons after one bit time.
    n          = cyc + 1;
    str_glitch = 1'b1;
    prescale   = PW'(8);
    rx_in      = 1'b0;
    push_ev(K_STR, n + 6, 6, 0);
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("glitch_cyc", cyc, n + 7);
    chk("glitch_last_dat_samp_en", int'(dat_samp_en), 1);
    chk("glitch_last_edge_cnt", int'(edge_cnt), 7);
    @(posedge clk);
    #1;
    chk("glitch_idle_dat_samp_en", int'(dat_samp_en), 0);
    chk("glitch_idle_edge_cnt", int'(edge_cnt), 0);
    str_glitch = 1'b0;
    idle(4);
    chk("glitch_stays_idle", int'(dat_samp_en), 0);
    chk("sb_after_glitch", sb.size(), 0);

    // Parity error: stop still consumed, no data_valid; next no-parity frame is clean.
    send_frame(8, 1'b1, 8'h5A, 1'b1, 1'b0, -1, -1, 0);
    idle(2);
    send_frame(8, 1'b0, 8'h81, 1'b0, 1'b0, -1, -1, 0);
    idle(3);
    chk("sb_after_par_err", sb.size(), 0);

    // Stop error, then two back-to-back x16 frames starting in the data_valid cycle.
    send_frame(8, 1'b0, 8'hF0, 1'b0, 1'b1, -1, -1, 0);
    idle(2);
    send_frame(16, 1'b0, 8'h12, 1'b0, 1'b0, -1, -1, 0);
    @(posedge clk);
    #1;
    chk("b2b_dv_cycle_idle", int'(dat_samp_en), 0);
    send_frame(16, 1'b0, 8'hED, 1'b0, 1'b0, -1, -1, 0);
    idle(3);
    chk("sb_after_b2b", sb.size(), 0);

    // Prescale raised to 16 during bit 3 of an x8 frame; the next frame runs at x16.
    send_frame(8, 1'b0, 8'h66, 1'b0, 1'b0, -1, 24, 16);
    idle(1);
    send_frame(16, 1'b1, 8'h99, 1'b0, 1'b0, -1, -1, 0);
    idle(3);
    chk("sb_after_prescale_change", sb.size(), 0);

    // Reset pulse during data bit 4 abandons the frame.
    send_frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 35, -1, 0);
    idle(100);
    chk("post_reset_idle", int'(dat_samp_en), 0);
    chk("sb_after_reset", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
